// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
//
// Elastic pipeline register placed between processor stages. It has a
// valid/ready handshake on both sides and a 2-entry store: a main register M
// that always drives DataOutput, and a skid register S that catches the one
// extra beat accepted in the cycle the downstream stalls. InReady is decoded
// from the registered state only, so a stall moves back one stage per cycle
// and never forms a combinational ready chain.
//
// Handshake: a transfer happens on a posedge of CLK when valid and ready are
// both 1 on that side. The producer may not assume acceptance without ready.
// While OutValid=1 and OutReady=0, OutValid and DataOutput stay constant.
//
// Optional feature: define PIPE_STAGE_STALLCNT_EN to add the StallCount output.
// It is a saturating 16-bit count of cycles with OutValid=1 and OutReady=0.
// Only Reset clears it; Flush does not.
//
// Parameters:
//   Widht       payload width in bits (>=1)
//   ResetValue  value loaded into M and S on Reset
//
// Ports:
//   CLK         clock, all state updates on posedge
//   Reset       synchronous, active-high reset; overrides everything
//   Flush       synchronous discard of all held entries
//   InValid     upstream presents DataInput
//   InReady     stage can accept (registered decode of state)
//   DataInput   upstream payload
//   OutValid    DataOutput holds a valid entry
//   OutReady    downstream accepts DataOutput this cycle
//   DataOutput  head payload, driven from M
//   StallCount  saturating stall counter (PIPE_STAGE_STALLCNT_EN only)
//   DbgState    current FSM state: 0 EMPTY, 1 FULL, 2 SKID
// -----------------------------------------------------------------------------
module pipe_stage_reg #(
  parameter int                Widht      = 32,
  parameter logic [Widht-1:0]  ResetValue = '0
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              Flush,
  input  logic              InValid,
  output logic              InReady,
  input  logic [Widht-1:0]  DataInput,
  output logic              OutValid,
  input  logic              OutReady,
  output logic [Widht-1:0]  DataOutput,
`ifdef PIPE_STAGE_STALLCNT_EN
  output logic [15:0]       StallCount,
`endif
  output logic [1:0]        DbgState
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_FULL  = 2'b01,
    ST_SKID  = 2'b10
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [Widht-1:0]  r_main;
  logic [Widht-1:0]  r_skid;
  logic              w_load_main;
  logic              w_main_from_skid;
  logic              w_load_skid;
  logic              w_out_valid;
  logic              w_in_ready;

  // Outputs depend on the registered state only. The unused encoding 2'b11
  // reads as neither valid nor ready, and the next-state logic leaves it
  // for EMPTY on the following edge.
  assign w_out_valid = (r_state == ST_FULL) || (r_state == ST_SKID);
  assign w_in_ready  = (r_state == ST_EMPTY) || (r_state == ST_FULL);

  assign OutValid   = w_out_valid;
  assign InReady    = w_in_ready;
  assign DataOutput = r_main;
  assign DbgState   = r_state;

  always_comb begin
    w_state_nxt      = ST_EMPTY;
    w_load_main      = 1'b0;
    w_main_from_skid = 1'b0;
    w_load_skid      = 1'b0;

    case (r_state)
      ST_EMPTY: begin
        if (InValid) begin
          w_load_main = 1'b1;
          w_state_nxt = ST_FULL;
        end else begin
          w_state_nxt = ST_EMPTY;
        end
      end
      ST_FULL: begin
        case ({InValid, OutReady})
          2'b11: begin
            // The head leaves and the new beat replaces it in the same cycle.
            w_load_main = 1'b1;
            w_state_nxt = ST_FULL;
          end
          2'b10: begin
            // Downstream stalled: park the accepted beat behind the head.
            w_load_skid = 1'b1;
            w_state_nxt = ST_SKID;
          end
          2'b01:   w_state_nxt = ST_EMPTY;
          default: w_state_nxt = ST_FULL;
        endcase
      end
      ST_SKID: begin
        if (OutReady) begin
          w_load_main      = 1'b1;
          w_main_from_skid = 1'b1;
          w_state_nxt      = ST_FULL;
        end else begin
          w_state_nxt = ST_SKID;
        end
      end
      default: w_state_nxt = ST_EMPTY;
    endcase

    // Flush drops whatever is held and any beat offered in the same cycle.
    if (Flush) begin
      w_state_nxt      = ST_EMPTY;
      w_load_main      = 1'b0;
      w_main_from_skid = 1'b0;
      w_load_skid      = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_state <= ST_EMPTY;
      r_main  <= ResetValue;
      r_skid  <= ResetValue;
    end else begin
      r_state <= w_state_nxt;
      if (w_load_main) begin
        r_main <= w_main_from_skid ? r_skid : DataInput;
      end
      if (w_load_skid) begin
        r_skid <= DataInput;
      end
    end
  end

`ifdef PIPE_STAGE_STALLCNT_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_stall_cnt <= 16'h0000;
    end else if (w_out_valid && !OutReady && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'h0001;
    end
  end

  assign StallCount = r_stall_cnt;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_reg
//
// Bench for pipe_stage_reg. A queue of at most two entries models the stage's
// contents. OutValid means the queue is non-empty, InReady means it holds
// fewer than two entries, and DataOutput is the queue head. A compare process
// checks the DUT against this model on every negedge. Directed sections add
// hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_pipe_stage_reg;

  localparam int W = 32;

  logic          CLK;
  logic          Reset;
  logic          Flush;
  logic          InValid;
  logic          InReady;
  logic [W-1:0]  DataInput;
  logic          OutValid;
  logic          OutReady;
  logic [W-1:0]  DataOutput;
  logic [1:0]    DbgState;
`ifdef PIPE_STAGE_STALLCNT_EN
  logic [15:0]   StallCount;
`endif

  int errors = 0;
  int checks = 0;

  // Model state.
  logic [W-1:0]  exp_q[$];
  logic          model_on = 1'b0;
  int unsigned   pre_sz;
  logic          prev_stall = 1'b0;
  logic [W-1:0]  prev_data;
  logic [15:0]   exp_stall = 16'h0000;

  pipe_stage_reg #(
    .Widht      (W),
    .ResetValue ('0)
  ) dut (
    .CLK        (CLK),
    .Reset      (Reset),
    .Flush      (Flush),
    .InValid    (InValid),
    .InReady    (InReady),
    .DataInput  (DataInput),
    .OutValid   (OutValid),
    .OutReady   (OutReady),
    .DataOutput (DataOutput),
`ifdef PIPE_STAGE_STALLCNT_EN
    .StallCount (StallCount),
`endif
    .DbgState   (DbgState)
  );

  // ---------------------------------------------------------------- clock
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------------------------------------------------------- checker
  task automatic check(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- model
  always @(posedge CLK) begin
    pre_sz = exp_q.size();
    if (Reset) begin
      exp_q.delete();
      model_on   = 1'b1;
      exp_stall  = 16'h0000;
      prev_stall = 1'b0;
    end else begin
      if (pre_sz > 0 && !OutReady && exp_stall != 16'hFFFF)
        exp_stall = exp_stall + 16'h0001;
      prev_stall = !Flush && (pre_sz > 0) && !OutReady;
      if (pre_sz > 0) prev_data = exp_q[0];
      if (Flush) begin
        exp_q.delete();
      end else begin
        if (pre_sz > 0 && OutReady) void'(exp_q.pop_front());
        if (InValid && pre_sz < 2) exp_q.push_back(DataInput);
      end
    end
  end

  // ---------------------------------------------------------------- compare
  always @(negedge CLK) begin
    if (model_on) begin
      check("out_valid", {31'b0, OutValid}, {31'b0, exp_q.size() > 0});
      check("in_ready",  {31'b0, InReady},  {31'b0, exp_q.size() < 2});
      if (exp_q.size() > 0) check("data_out", DataOutput, exp_q[0]);
      if (prev_stall) begin
        check("stall_hold_valid", {31'b0, OutValid}, 32'd1);
        check("stall_hold_data", DataOutput, prev_data);
      end
`ifdef PIPE_STAGE_STALLCNT_EN
      check("stall_count", {16'b0, StallCount}, {16'b0, exp_stall});
`endif
    end
  end

  // ---------------------------------------------------------------- driver
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic v, input logic [W-1:0] d, input logic r);
    InValid   = v;
    DataInput = d;
    OutReady  = r;
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    int n_rand;
    Reset = 1'b1;
    Flush = 1'b0;
    drive(1'b1, 32'hDEAD_BEEF, 1'b0);

    // Test 1: reset with a live upstream beat.
    for (int k = 0; k < 2; k++) begin
      step();
      check("t1_valid", {31'b0, OutValid}, 32'd0);
      check("t1_ready", {31'b0, InReady}, 32'd1);
      check("t1_data", DataOutput, 32'h0);
    end
    Reset = 1'b0;
    drive(1'b0, 32'h0, 1'b0);
    step();
    check("t1_post_valid", {31'b0, OutValid}, 32'd0);
    check("t1_post_ready", {31'b0, InReady}, 32'd1);
    check("t1_post_data", DataOutput, 32'h0);

    // Test 2: full-throughput stream.
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, W'(i), 1'b1);
      step();
      check("t2_valid", {31'b0, OutValid}, 32'd1);
      check("t2_ready", {31'b0, InReady}, 32'd1);
      check("t2_data", DataOutput, W'(i));
    end
    drive(1'b0, 32'h0, 1'b1);
    step();
    check("t2_drain", {31'b0, OutValid}, 32'd0);

    // Test 3: backpressure into the skid register.
    drive(1'b1, 32'hA, 1'b1);
    step();
    check("t3_a", DataOutput, 32'hA);
    drive(1'b1, 32'hB, 1'b0);
    step();
    check("t3_skid_data", DataOutput, 32'hA);
    check("t3_skid_ready", {31'b0, InReady}, 32'd0);
    check("t3_skid_state", {30'b0, DbgState}, 32'd2);
    drive(1'b1, 32'hC, 1'b0);
    step();
    check("t3_hold_data", DataOutput, 32'hA);
    check("t3_hold_ready", {31'b0, InReady}, 32'd0);
    drive(1'b1, 32'hC, 1'b1);
    step();
    check("t3_b", DataOutput, 32'hB);
    check("t3_b_ready", {31'b0, InReady}, 32'd1);
    step();
    check("t3_c", DataOutput, 32'hC);
    drive(1'b0, 32'h0, 1'b1);
    step();
    check("t3_empty", {31'b0, OutValid}, 32'd0);

    // Test 4: flush from SKID, then flush from FULL with a live input beat.
    drive(1'b1, 32'h11, 1'b0);
    step();
    drive(1'b1, 32'h22, 1'b0);
    step();
    check("t4_skid_data", DataOutput, 32'h11);
    check("t4_skid_ready", {31'b0, InReady}, 32'd0);
    Flush = 1'b1;
    drive(1'b1, 32'h33, 1'b0);
    step();
    Flush = 1'b0;
    check("t4_flush_valid", {31'b0, OutValid}, 32'd0);
    check("t4_flush_ready", {31'b0, InReady}, 32'd1);
    drive(1'b0, 32'h0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      step();
      check("t4_no_33", {31'b0, OutValid}, 32'd0);
    end
    drive(1'b1, 32'h44, 1'b0);
    step();
    Flush = 1'b1;
    drive(1'b1, 32'h55, 1'b1);
    step();
    Flush = 1'b0;
    drive(1'b0, 32'h0, 1'b1);
    check("t4_full_flush", {31'b0, OutValid}, 32'd0);

    // Reset in the middle of operation drops both entries.
    drive(1'b1, 32'h66, 1'b0);
    step();
    drive(1'b1, 32'h77, 1'b0);
    step();
    Reset = 1'b1;
    drive(1'b1, 32'h88, 1'b1);
    step();
    Reset = 1'b0;
    drive(1'b0, 32'h0, 1'b1);
    check("t4_rst_valid", {31'b0, OutValid}, 32'd0);
    check("t4_rst_ready", {31'b0, InReady}, 32'd1);
    check("t4_rst_data", DataOutput, 32'h0);
    step();

    // Test 5: random traffic against the model.
`ifdef PIPE_STAGE_STALLCNT_EN
    n_rand = 2000;
`else
    n_rand = 10000;
`endif
    for (int i = 0; i < n_rand; i++) begin
      drive($urandom_range(0, 99) < 50, $urandom, $urandom_range(0, 99) < 30);
      if (i % 16 == 0) begin
        // Toggling OutReady mid-cycle must not move InReady.
        #1;
        OutReady = !OutReady;
        #1;
        check("in_ready_comb", {31'b0, InReady}, {31'b0, exp_q.size() < 2});
        OutReady = !OutReady;
      end
      step();
    end
    drive(1'b0, 32'h0, 1'b1);
    step();
    step();
    step();
    check("t5_drained", {31'b0, OutValid}, 32'd0);

`ifdef PIPE_STAGE_STALLCNT_EN
    // Test 6: stall counter saturation, survives Flush, cleared by Reset.
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    drive(1'b1, 32'h99, 1'b0);
    step();
    drive(1'b0, 32'h0, 1'b0);
    repeat (70000) @(posedge CLK);
    #1;
    check("t6_sat", {16'b0, StallCount}, 32'h0000_FFFF);
    Flush = 1'b1;
    step();
    Flush = 1'b0;
    check("t6_flush_keeps", {16'b0, StallCount}, 32'h0000_FFFF);
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    check("t6_reset_clears", {16'b0, StallCount}, 32'h0);
    step();
`endif

    @(negedge CLK);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised elastic pipeline register; successor to the single enable-gated register in the processor datapath.
- Adds a valid/ready handshake on both sides, a 2-entry skid buffer for full throughput under backpressure, and a synchronous flush.
- Sits between processor pipeline stages (e.g. fetch->decode, decode->execute), so a stall propagates one stage per cycle without combinational ready paths.

Parameters:
Widht, 32, payload width in bits (>=1)
ResetValue, 0, value loaded into both data registers on Reset

Ports:
CLK  input  1  clock, all state updates on posedge
Reset  input  1  synchronous, active-high reset; highest priority
Flush  input  1  synchronous discard of all held entries
InValid  input  1  upstream presents DataInput
InReady  output  1  stage can accept; registered (decoded from state, no comb path from OutReady)
DataInput  input  Widht  upstream payload
OutValid  output  1  DataOutput holds a valid entry
OutReady  input  1  downstream accepts DataOutput this cycle
DataOutput  output  Widht  head payload, driven from main register
StallCount  output  16  present only with PIPE_STAGE_STALLCNT_EN (see Optional Feature)

Behaviour:
- Reset: clock is CLK; reset is Reset, synchronous, active-high.
- Transfers:
  - Input transfer = InValid & InReady.
  - Output transfer = OutValid & OutReady.
  - Both evaluated at posedge CLK.
- Storage: main register M (drives DataOutput), skid register S.
- State machine:
  - EMPTY: OutValid=0, InReady=1.
  - FULL: OutValid=1, InReady=1.
  - SKID: OutValid=1, InReady=0.
- Transitions (Reset=0, Flush=0):
  - EMPTY: InValid -> M<=DataInput, go FULL; else stay.
  - FULL, InValid & OutReady -> M<=DataInput, stay FULL (1 entry/cycle throughput).
  - FULL, InValid & !OutReady -> S<=DataInput, go SKID.
  - FULL, !InValid & OutReady -> go EMPTY; M unchanged.
  - FULL, !InValid & !OutReady -> hold.
  - SKID: OutReady -> M<=S, go FULL; else hold. InValid is ignored (InReady=0).
- Latency: input transfer at edge N -> OutValid=1 with that data after edge N (visible cycle N+1) when stage was EMPTY or drained.
- Ordering: strict FIFO; S never overtakes M.
- Data stability: while OutValid=1 and OutReady=0, DataOutput and OutValid must not change.
- Flush (Reset=0):
  - Next state EMPTY; OutValid=0, InReady=1 after the edge.
  - Any same-cycle input transfer is dropped.
  - M/S contents unchanged (don't-care).
- Reset:
  - State EMPTY; M=S=ResetValue; OutValid=0; InReady=1.
  - DataOutput=ResetValue; StallCount=0.
  - Overrides Flush and any handshake.
  - Reset mid-operation discards both entries.
- No X propagation: state encoding must fully decode; any illegal state returns to EMPTY.

Optional Feature:
Macro: PIPE_STAGE_STALLCNT_EN.
- Defined:
  - StallCount port exists.
  - Increments by 1 each cycle OutValid=1 & OutReady=0.
  - Saturates at 16'hFFFF.
  - Cleared by Reset only; Flush does not clear it.
- Undefined: port and counter logic absent; handshake behaviour identical.

Test Plan:
1. Reset asserted 2 cycles with InValid=1, DataInput=32'hDEAD_BEEF -> OutValid=0, InReady=1, DataOutput=0 throughout and one cycle after release.
2. Stream 0x1..0x8 with InValid=1, OutReady=1 constantly -> DataOutput 0x1..0x8 on consecutive cycles, 1-cycle latency, no bubbles, InReady stays 1.
3. Stream 0xA,0xB,0xC; drop OutReady on the cycle 0xA is at output -> 0xB captured in S, InReady=0; 0xC held upstream; raise OutReady -> output 0xA,0xB,0xC in order, no loss or duplication.
4. SKID state holding 0x11 (M) / 0x22 (S); assert Flush with InValid=1, DataInput=0x33 -> next cycle OutValid=0, InReady=1; 0x33 never appears at output.
5. Random InValid/OutReady (50%/30%) for 10,000 cycles vs. scoreboard queue -> exact in-order match, DataOutput stable while stalled, InReady never depends combinationally on OutReady.
6. (PIPE_STAGE_STALLCNT_EN) hold OutValid=1, OutReady=0 for 70,000 cycles -> StallCount saturates at 16'hFFFF; Flush leaves it; Reset clears to 0.
